// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_pkg
//  Description : Shared definitions for the Avalon-MM SPI master: register
//                word addresses, STATUS/CONTROL bit positions and the frame
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

    // Avalon word addresses
    localparam logic [7:0] ADDR_TXDATA  = 8'h00;
    localparam logic [7:0] ADDR_RXDATA  = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_CONTROL = 8'h03;

    // STATUS bit positions
    localparam int STAT_BUSY     = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_RX_VALID = 3;
    localparam int STAT_TX_OVF   = 4;
    localparam int STAT_DONE     = 5;
    localparam int STAT_RX_OVR   = 6;

    // CONTROL bit positions
    localparam int CTRL_IRQ_EN   = 0;
    localparam int CTRL_CS_HOLD  = 1;
    localparam int CTRL_DIV_LSB  = 16;

    // Frame state machine
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        TRAIL    = 3'd4,
        GAP      = 3'd5
    } spi_state_e;

endpackage : spi_master_pkg
`default_nettype wire

// File: rtl/spi_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_fifo
//  Description : Synchronous 8-bit FIFO holding bytes waiting to be shifted
//                out. A push into a full FIFO is accepted when a pop happens
//                in the same cycle.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push/i_push_data - write request and byte
//                i_pop / o_pop_data - read request and head byte (show-ahead)
//                o_full / o_empty   - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_pop_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_full     = (r_count == c_full);
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    // The slot freed by a same-cycle pop makes room for the push.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : spi_tx_fifo
`default_nettype wire

// File: rtl/spi_master_avs.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_avs
//  Description : Avalon-MM controlled SPI master, mode 0, MSB first, 8-bit
//                frames. Bytes written to TXDATA are queued and shifted out;
//                each received byte is exposed in RXDATA and on data_out.
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                SPI_clk/CS/SDO/SDI     - SPI bus (outputs registered)
//                data_out(_enable)      - received byte and one-cycle strobe
//                avs_s0_*               - Avalon-MM slave (2-cycle reads)
//                ins_irq0_irq           - level interrupt (IRQ_EN & DONE)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_avs #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_DEFAULT = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        SPI_clk,
    output logic        SPI_CS,
    output logic        SPI_SDO,
    input  logic        SPI_SDI,
    output logic [7:0]  data_out,
    output logic        data_out_enable,
    input  logic [7:0]  avs_s0_address,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    output logic        avs_s0_waitrequest,
    output logic        ins_irq0_irq
);

    import spi_master_pkg::*;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    spi_state_e  r_state;
    spi_state_e  w_state_next;
    logic [7:0]  r_cnt;
    logic        r_first;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_tx_shift;
    logic [7:0]  w_tx_next;
    logic [7:0]  r_rx_shift;
    logic [7:0]  w_rx_next;
    logic        w_load;
    logic        w_pop;
    logic        w_shift;
    logic        w_frame_done;
    logic        w_phase_end;
    logic [7:0]  w_d;

    logic        r_irq_en;
    logic        r_cs_hold;
    logic [7:0]  r_div;
    logic        r_tx_ovf;
    logic        r_done;
    logic        r_rx_ovr;
    logic        r_rx_valid;

    logic        r_spi_clk;
    logic        r_spi_cs;
    logic        r_spi_sdo;
    logic [7:0]  r_data_out;
    logic        r_data_out_en;
    logic [31:0] r_readdata;
    logic        r_rd_ack;
    logic [31:0] w_rd_mux;
    logic [6:0]  w_status;

    logic        w_push_req;
    logic        w_wr_status;
    logic        w_wr_control;
    logic        w_rx_clear;
    logic        w_busy;
    logic [7:0]  w_fifo_head;
    logic        w_fifo_full;
    logic        w_fifo_empty;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    assign w_push_req = avs_s0_write & (avs_s0_address == ADDR_TXDATA);

    spi_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push_req),
        .i_push_data (avs_s0_writedata[7:0]),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    // DIV=0 would give a zero-length phase; clamp it to one cycle.
    assign w_d         = (r_div == 8'd0) ? 8'd1 : r_div;
    assign w_phase_end = (r_cnt == 8'd0);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        w_shift      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                if (w_phase_end) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (w_phase_end) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_phase_end) begin
                    w_load  = 1'b1;
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd0) begin
                        w_frame_done = 1'b1;
                        w_state_next = TRAIL;
                    end else begin
                        w_state_next = SHIFT_LO;
                    end
                end
            end
            TRAIL: begin
                if (w_phase_end) begin
                    w_load = 1'b1;
                    // Back-to-back frames under CS_HOLD skip SETUP and GAP.
                    if (r_cs_hold && !w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = SHIFT_LO;
                    end else begin
                        w_state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (w_phase_end) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_tx_next = r_tx_shift;
        if (w_pop) begin
            w_tx_next = w_fifo_head;
        end else if (w_shift) begin
            w_tx_next = {r_tx_shift[6:0], 1'b0};
        end
    end

    // SDI is taken once, in the first cycle of the high phase. The final
    // byte is built from w_rx_next so that with D=1 the bit sampled on the
    // completing edge is not lost.
    assign w_rx_next = (r_state == SHIFT_HI && r_first) ? {r_rx_shift[6:0], SPI_SDI}
                                                        : r_rx_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_first    <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_tx_shift <= 8'd0;
            r_rx_shift <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_first    <= w_load;
            r_tx_shift <= w_tx_next;
            r_rx_shift <= w_rx_next;
            // The divisor is latched on state entry, so CONTROL writes only
            // affect phases that start afterwards.
            if (w_load) begin
                r_cnt <= w_d - 8'd1;
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_pop) begin
                r_bit_cnt <= 3'd7;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
            end
        end
    end

    // SPI outputs are registered from the next state so they line up
    // exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spi_cs  <= 1'b1;
            r_spi_clk <= 1'b0;
            r_spi_sdo <= 1'b0;
        end else begin
            r_spi_cs  <= (w_state_next == IDLE) || (w_state_next == GAP);
            r_spi_clk <= (w_state_next == SHIFT_HI);
            r_spi_sdo <= (w_state_next != IDLE && w_state_next != GAP) ? w_tx_next[7] : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    assign w_wr_status  = avs_s0_write & (avs_s0_address == ADDR_STATUS);
    assign w_wr_control = avs_s0_write & (avs_s0_address == ADDR_CONTROL);
    // Read side effects occur in the second (completing) read cycle.
    assign w_rx_clear   = avs_s0_read & r_rd_ack & (avs_s0_address == ADDR_RXDATA);
    assign w_busy       = (r_state != IDLE) | ~w_fifo_empty;

    assign w_status = {r_rx_ovr, r_done, r_tx_ovf, r_rx_valid,
                       w_fifo_empty, w_fifo_full, w_busy};

    // Set events are checked before W1C clears so that a simultaneous set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en      <= 1'b0;
            r_cs_hold     <= 1'b0;
            r_div         <= 8'(DIV_DEFAULT);
            r_tx_ovf      <= 1'b0;
            r_done        <= 1'b0;
            r_rx_ovr      <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_data_out    <= 8'd0;
            r_data_out_en <= 1'b0;
        end else begin
            r_data_out_en <= w_frame_done;
            if (w_frame_done) begin
                r_data_out <= w_rx_next;
            end
            if (w_wr_control) begin
                r_irq_en  <= avs_s0_writedata[CTRL_IRQ_EN];
                r_cs_hold <= avs_s0_writedata[CTRL_CS_HOLD];
                r_div     <= avs_s0_writedata[CTRL_DIV_LSB +: 8];
            end
            if (w_push_req && w_fifo_full && !w_pop) begin
                r_tx_ovf <= 1'b1;
            end else if (w_wr_status && avs_s0_writedata[STAT_TX_OVF]) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_frame_done) begin
                r_done <= 1'b1;
            end else if (w_wr_status && avs_s0_writedata[STAT_DONE]) begin
                r_done <= 1'b0;
            end
            // A read completing with the new byte is not an overrun.
            if (w_frame_done && r_rx_valid && !w_rx_clear) begin
                r_rx_ovr <= 1'b1;
            end else if (w_wr_status && avs_s0_writedata[STAT_RX_OVR]) begin
                r_rx_ovr <= 1'b0;
            end
            if (w_frame_done) begin
                r_rx_valid <= 1'b1;
            end else if (w_rx_clear) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (avs_s0_address)
            ADDR_RXDATA:  w_rd_mux[7:0] = r_data_out;
            ADDR_STATUS:  w_rd_mux[6:0] = w_status;
            ADDR_CONTROL: begin
                w_rd_mux[CTRL_IRQ_EN]          = r_irq_en;
                w_rd_mux[CTRL_CS_HOLD]         = r_cs_hold;
                w_rd_mux[CTRL_DIV_LSB +: 8]    = r_div;
            end
            default:      w_rd_mux = 32'd0;
        endcase
    end

    // Two-cycle read: capture in the first cycle, acknowledge in the second.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'd0;
            r_rd_ack   <= 1'b0;
        end else begin
            r_rd_ack <= avs_s0_read & ~r_rd_ack;
            if (avs_s0_read && !r_rd_ack) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SPI_clk            = r_spi_clk;
    assign SPI_CS             = r_spi_cs;
    assign SPI_SDO            = r_spi_sdo;
    assign data_out           = r_data_out;
    assign data_out_enable    = r_data_out_en;
    assign avs_s0_readdata    = r_readdata;
    assign avs_s0_waitrequest = avs_s0_read & ~r_rd_ack;
    assign ins_irq0_irq       = r_irq_en & r_done;

endmodule : spi_master_avs
`default_nettype wire

// File: tb/tb_spi_master_avs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_avs
//  Description : Directed self-checking bench for spi_master_avs. SDI is
//                looped back to SDO so every received byte equals the byte
//                sent. Outputs are sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_avs;

    logic        clk = 1'b0;
    logic        reset;
    logic        SPI_clk;
    logic        SPI_CS;
    logic        SPI_SDO;
    logic        SPI_SDI;
    logic [7:0]  data_out;
    logic        data_out_enable;
    logic [7:0]  avs_s0_address;
    logic        avs_s0_read;
    logic [31:0] avs_s0_readdata;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic        avs_s0_waitrequest;
    logic        ins_irq0_irq;

    int n_checks = 0;
    int n_fail   = 0;

    // capture statistics
    int          cap_rises, cap_hi, cap_cs_low, cap_cs_rises, cap_cs_falls;
    int          cap_fall_idx, cap_doe, cap_doe_idx, cap_first_rise, cap_last_rise;
    logic [31:0] cap_sdo;
    logic [63:0] cap_hist;
    logic [7:0]  cap_doe_data;
    logic [31:0] rd;

    always #5 clk = ~clk;

    assign SPI_SDI = SPI_SDO;

    spi_master_avs #(
        .FIFO_DEPTH  (4),
        .DIV_DEFAULT (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .SPI_clk            (SPI_clk),
        .SPI_CS             (SPI_CS),
        .SPI_SDO            (SPI_SDO),
        .SPI_SDI            (SPI_SDI),
        .data_out           (data_out),
        .data_out_enable    (data_out_enable),
        .avs_s0_address     (avs_s0_address),
        .avs_s0_read        (avs_s0_read),
        .avs_s0_readdata    (avs_s0_readdata),
        .avs_s0_write       (avs_s0_write),
        .avs_s0_writedata   (avs_s0_writedata),
        .avs_s0_waitrequest (avs_s0_waitrequest),
        .ins_irq0_irq       (ins_irq0_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling clock edge.
    task automatic avs_write(input logic [7:0] addr, input logic [31:0] data);
        avs_s0_address   = addr;
        avs_s0_writedata = data;
        avs_s0_write     = 1'b1;
        @(negedge clk);
        avs_s0_write     = 1'b0;
    endtask

    task automatic avs_read(input logic [7:0] addr, output logic [31:0] data);
        bit got;
        got            = 1'b0;
        data           = 32'd0;
        avs_s0_address = addr;
        avs_s0_read    = 1'b1;
        #1;
        check("rd_wait_first", {31'd0, avs_s0_waitrequest}, 32'd1);
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (!avs_s0_waitrequest) begin
                got  = 1'b1;
                data = avs_s0_readdata;
            end
        end
        check("rd_ack", {31'd0, got}, 32'd1);
        @(negedge clk);
        avs_s0_read = 1'b0;
    endtask

    task automatic capture(input int n);
        logic prev_clk, prev_cs;
        cap_rises = 0; cap_hi = 0; cap_cs_low = 0; cap_cs_rises = 0; cap_cs_falls = 0;
        cap_fall_idx = -1; cap_doe = 0; cap_doe_idx = -1; cap_first_rise = -1;
        cap_last_rise = -1; cap_sdo = 32'd0; cap_hist = 64'd0; cap_doe_data = 8'd0;
        prev_clk = SPI_clk;
        prev_cs  = SPI_CS;
        for (int i = 0; i < n; i++) begin
            if (SPI_clk && !prev_clk) begin
                cap_rises++;
                cap_sdo = {cap_sdo[30:0], SPI_SDO};
                if (cap_first_rise < 0) cap_first_rise = i;
                cap_last_rise = i;
            end
            if (SPI_clk) cap_hi++;
            if (!SPI_CS) cap_cs_low++;
            if (SPI_CS && !prev_cs) cap_cs_rises++;
            if (!SPI_CS && prev_cs) begin
                cap_cs_falls++;
                if (cap_fall_idx < 0) cap_fall_idx = i;
            end
            if (data_out_enable) begin
                cap_doe++;
                cap_hist = {cap_hist[55:0], data_out};
                if (cap_doe_idx < 0) begin
                    cap_doe_idx  = i;
                    cap_doe_data = data_out;
                end
            end
            prev_clk = SPI_clk;
            prev_cs  = SPI_CS;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   found;
        bit   prev;
        int   rises;
        reset            = 1'b1;
        avs_s0_address   = 8'd0;
        avs_s0_read      = 1'b0;
        avs_s0_write     = 1'b0;
        avs_s0_writedata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // ---------------- reset state ----------------
        check("rst_cs",   {31'd0, SPI_CS}, 32'd1);
        check("rst_sclk", {31'd0, SPI_clk}, 32'd0);
        check("rst_sdo",  {31'd0, SPI_SDO}, 32'd0);
        check("rst_dout", {24'd0, data_out}, 32'd0);
        check("rst_doe",  {31'd0, data_out_enable}, 32'd0);
        check("rst_rdata", avs_s0_readdata, 32'd0);
        check("rst_wait", {31'd0, avs_s0_waitrequest}, 32'd0);
        check("rst_irq",  {31'd0, ins_irq0_irq}, 32'd0);
        avs_read(8'h02, rd); check("rst_status", rd, 32'h04);
        avs_read(8'h03, rd); check("rst_control", rd, 32'h0004_0000);
        avs_read(8'h10, rd); check("unmapped", rd, 32'd0);

        // ---------------- single frame 0xA5, D=4 ----------------
        avs_write(8'h00, 32'h0000_00A5);
        capture(90);
        check("t1_cs_fall", cap_fall_idx, 1);
        check("t1_cs_low", cap_cs_low, 72);
        check("t1_rises", cap_rises, 8);
        check("t1_sdo", cap_sdo, 32'hA5);
        check("t1_hi_cycles", cap_hi, 32);
        check("t1_doe_cnt", cap_doe, 1);
        check("t1_doe_lat", cap_doe_idx - cap_fall_idx, 68);
        check("t1_dout", {24'd0, cap_doe_data}, 32'hA5);
        avs_read(8'h02, rd); check("t1_status", rd, 32'h2C);
        avs_read(8'h01, rd); check("t1_rxdata", rd, 32'hA5);
        avs_read(8'h02, rd); check("t1_status2", rd, 32'h24);

        // ---------------- FIFO fill and overflow ----------------
        avs_write(8'h02, 32'h20);
        avs_write(8'h00, 32'h11);
        avs_write(8'h00, 32'h22);
        avs_write(8'h00, 32'h33);
        avs_write(8'h00, 32'h44);
        avs_write(8'h00, 32'h55);
        avs_read(8'h02, rd); check("t2_full", rd, 32'h03);
        avs_write(8'h00, 32'h66);
        avs_read(8'h02, rd); check("t2_ovf", rd, 32'h13);
        capture(420);
        check("t2_doe_cnt", cap_doe, 5);
        check("t2_hist_hi", {24'd0, cap_hist[39:32]}, 32'h11);
        check("t2_hist_lo", cap_hist[31:0], 32'h2233_4455);
        avs_read(8'h02, rd); check("t2_status", rd, 32'h7C);
        avs_write(8'h02, 32'h70);
        avs_read(8'h02, rd); check("t2_w1c", rd, 32'h0C);

        // ---------------- CS_HOLD, three frames ----------------
        avs_read(8'h01, rd); check("t3_rx_prev", rd, 32'h55);
        avs_write(8'h03, 32'h0004_0002);
        avs_write(8'h00, 32'h81);
        avs_write(8'h00, 32'h42);
        avs_write(8'h00, 32'hC3);
        capture(260);
        check("t3_rises", cap_rises, 24);
        check("t3_cs_rises", cap_cs_rises, 1);
        check("t3_cs_falls", cap_cs_falls, 0);
        check("t3_sdo", cap_sdo, 32'h0081_42C3);
        check("t3_doe_cnt", cap_doe, 3);
        check("t3_hist", cap_hist[31:0], 32'h0081_42C3);
        avs_read(8'h02, rd); check("t3_status", rd, 32'h6C);

        // ---------------- interrupt ----------------
        avs_write(8'h02, 32'h70);
        avs_read(8'h01, rd); check("t4_rx_prev", rd, 32'hC3);
        avs_write(8'h03, 32'h0004_0001);
        check("t4_irq_idle", {31'd0, ins_irq0_irq}, 32'd0);
        avs_write(8'h00, 32'h3C);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (data_out_enable) found = 1'b1;
        end
        check("t4_doe_seen", {31'd0, found}, 32'd1);
        check("t4_irq_set", {31'd0, ins_irq0_irq}, 32'd1);
        check("t4_dout", {24'd0, data_out}, 32'h3C);
        avs_write(8'h02, 32'h20);
        check("t4_irq_clr", {31'd0, ins_irq0_irq}, 32'd0);
        repeat (10) @(negedge clk);

        // ---------------- DIV=0 behaves as DIV=1 ----------------
        avs_write(8'h03, 32'h0000_0000);
        avs_write(8'h00, 32'h96);
        capture(30);
        check("t5_rises", cap_rises, 8);
        check("t5_hi_cycles", cap_hi, 8);
        check("t5_span", cap_last_rise - cap_first_rise, 14);
        check("t5_cs_low", cap_cs_low, 18);
        check("t5_sdo", cap_sdo, 32'h96);
        check("t5_dout", {24'd0, cap_doe_data}, 32'h96);

        // ---------------- reset in SHIFT_HI of bit 3 ----------------
        avs_write(8'h03, 32'h0004_0000);
        avs_write(8'h00, 32'h0F);
        avs_write(8'h00, 32'hAA);
        rises = 0;
        prev  = SPI_clk;
        for (int k = 0; k < 200 && rises < 5; k++) begin
            @(negedge clk);
            if (SPI_clk && !prev) rises++;
            prev = SPI_clk;
        end
        check("t6_reach_bit3", rises, 5);
        check("t6_sdo_bit3", {31'd0, SPI_SDO}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_cs", {31'd0, SPI_CS}, 32'd1);
        check("t6_sclk", {31'd0, SPI_clk}, 32'd0);
        check("t6_sdo", {31'd0, SPI_SDO}, 32'd0);
        check("t6_doe", {31'd0, data_out_enable}, 32'd0);
        check("t6_dout", {24'd0, data_out}, 32'd0);
        reset = 1'b0;
        avs_read(8'h02, rd); check("t6_status", rd, 32'h04);
        capture(100);
        check("t6_no_doe", cap_doe, 0);
        check("t6_no_sclk", cap_rises, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_master_avs
`default_nettype wire

// File: doc/spi_master_avs.md
# spi_master_avs

- Avalon-MM controlled SPI master (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames).
- It is the initiator counterpart of the SPI slave peripheral: the Nios writes bytes into a TX FIFO, and the block clocks them out on SPI_clk/SPI_SDO.
- Each byte shifted in on SPI_SDI is captured into RXDATA and also streamed on data_out.
- Completion is signalled by interrupt.

## Interface
Parameters:
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of 2, ≥2.
- DIV_DEFAULT, 4: reset value of the half-period divisor, in clk cycles.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- SPI_clk  out  1  SPI serial clock.
- SPI_CS  out  1  chip select, active low.
- SPI_SDO  out  1  MOSI.
- SPI_SDI  in  1  MISO; already synchronised externally.
- data_out  out  8  last received byte.
- data_out_enable  out  1  one-cycle pulse when data_out updates.
- avs_s0_address  in  8  word address.
- avs_s0_read  in  1  Avalon read strobe.
- avs_s0_readdata  out  32  Avalon read data.
- avs_s0_write  in  1  Avalon write strobe.
- avs_s0_writedata  in  32  Avalon write data.
- avs_s0_waitrequest  out  1  Avalon wait request.
- ins_irq0_irq  out  1  level interrupt.

## Operation
Register map; unlisted addresses read 0 and ignore writes.
- 0x00 TXDATA (W):
  - Writes push writedata[7:0] into the TX FIFO.
  - If the FIFO is full, the write is dropped and TX_OVF is set.
- 0x01 RXDATA (R):
  - [7:0] returns the last received byte.
  - The read clears RX_VALID.
- 0x02 STATUS (R / W1C):
  - b0 BUSY, b1 TX_FULL, b2 TX_EMPTY, b3 RX_VALID.
  - b4 TX_OVF (W1C), b5 DONE (W1C), b6 RX_OVR (W1C).
- 0x03 CONTROL (RW):
  - b0 IRQ_EN.
  - b1 CS_HOLD: keep CS low across back-to-back frames.
  - [23:16] DIV.
  - Reset value: IRQ_EN=0, CS_HOLD=0, DIV=DIV_DEFAULT.
  - DIV=0 behaves as DIV=1.

Frame FSM: IDLE → SETUP → SHIFT_LO ↔ SHIFT_HI → TRAIL → GAP → IDLE. A divisor counter times every state for D = max(DIV,1) cycles.
- IDLE:
  - SPI_CS=1, SPI_clk=0.
  - When the FIFO is non-empty: pop the head into the shift register, set bit count to 7, go to SETUP.
- SETUP:
  - CS=0, SDO=MSB, for D cycles.
- SHIFT_LO:
  - SPI_clk=0 for D cycles, SDO holds the current bit.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - SPI_clk=1 for D cycles.
  - SDI is sampled in the first cycle of SHIFT_HI.
  - On exit, shift left; SDO takes the next bit.
  - If this was bit 0, go to TRAIL; otherwise go to SHIFT_LO.
- TRAIL (SPI_clk=0, CS=0, D cycles). Frame completes:
  - RXDATA, data_out and data_out_enable update.
  - DONE is set.
  - If RX_VALID was already 1, RX_OVR is set; then RX_VALID=1.
  - If CS_HOLD=1 and the FIFO is non-empty: pop and go directly to SHIFT_LO (no SETUP, no GAP).
  - Otherwise go to GAP.
- GAP:
  - CS=1 for D cycles, then IDLE.
- BUSY = (state ≠ IDLE) or FIFO non-empty.
- ins_irq0_irq = IRQ_EN & DONE.

Boundary rules:
- Write to a full FIFO in the same cycle as an FSM pop: the pop happens first and the write is accepted.
- RXDATA read in the same cycle as frame completion: the new byte wins; RX_VALID stays 1 and RX_OVR is not set.
- W1C in the same cycle as the set event: set wins.
- CONTROL writes take effect at the next state entry; an in-progress phase keeps its old D.
- Reset mid-frame, on the next edge:
  - SPI_CS=1, SPI_clk=0, SPI_SDO=0.
  - FIFO emptied, all status bits 0.
  - State = IDLE.
  - No data_out_enable pulse.

## Timing
Reset values of outputs:
- SPI_CS=1, SPI_clk=0, SPI_SDO=0.
- data_out=0, data_out_enable=0.
- readdata=0, waitrequest=0, irq=0.

Avalon:
- Writes take effect in the same cycle; no wait.
- Reads:
  - waitrequest=1 in the first read cycle and 0 in the second.
  - readdata is registered and valid in the second cycle.
  - The side-effect (RX_VALID clear) happens in the second cycle.

SPI:
- All SPI outputs are registered.
- The first frame's CS falls 2 cycles after the TXDATA write (FIFO write, then IDLE pop).
- Single frame, D=4: CS low for 4+64+4 = 72 cycles, then 4 cycles high. Total 76 cycles to IDLE.
- data_out_enable pulses on the first TRAIL cycle, 68 cycles after CS falls.

## Structure
- Package spi_master_pkg:
  - register address localparams (ADDR_TXDATA..ADDR_CONTROL);
  - STATUS/CONTROL bit indices;
  - FSM state enum (IDLE, SETUP, SHIFT_LO, SHIFT_HI, TRAIL, GAP).
- Sub-module spi_tx_fifo:
  - synchronous FIFO, 8-bit wide, FIFO_DEPTH entries;
  - push/pop/full/empty; pop+push when full is allowed.
- The FSM, divisor counter, shift register and register file live in the top level.

## Test plan
- Write 0xA5, D=4, SDI looped to SDO:
  - SDO shows 1,0,1,0,0,1,0,1 on successive rising SPI_clk;
  - data_out=0xA5 with a one-cycle enable;
  - STATUS reads 0x2C (TX_EMPTY, RX_VALID, DONE), then 0x24 after an RXDATA read.
- Write 5 bytes back-to-back with FIFO_DEPTH=4 while IDLE: first pops immediately, 4 queued, the 5th is still accepted; a 6th write sets TX_OVF (STATUS b4).
- CS_HOLD=1, 3 bytes queued: CS stays low across all 24 SPI_clk pulses, then rises once; RX_OVR=1 if RXDATA is not read.
- IRQ_EN=1: irq rises with DONE at frame end; a W1C write of 0x20 to STATUS deasserts irq on the next cycle.
- DIV=0 written: SPI_clk high and low phases are each 1 clk cycle, 8 pulses per frame.
- Reset asserted while in SHIFT_HI of bit 3: next edge shows CS=1, clk=0, STATUS=0x04, no data_out_enable.
